// File: rtl/ptw_pkg.sv
// ptw_pkg: shared definitions for the two-level page-table walker.
//   - PTE bit positions and the mask that turns a pointer PTE into a table base.
//   - Default root table address.
//   - FSM state encodings (3-bit) and the state enum built on them.
//   - index_offset(): turns a 10-bit VPN slice into a byte offset into a table.
package ptw_pkg;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;

  localparam logic [31:0] PTE_BASE_MASK     = 32'hFFFF_FFF0;
  localparam logic [31:0] ROOT_BASE_DEFAULT = 32'h0000_0400;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_L1_REQ  = 3'd1;
  localparam logic [2:0] S_L1_WAIT = 3'd2;
  localparam logic [2:0] S_L2_REQ  = 3'd3;
  localparam logic [2:0] S_L2_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_L1_REQ  = S_L1_REQ,
    ST_L1_WAIT = S_L1_WAIT,
    ST_L2_REQ  = S_L2_REQ,
    ST_L2_WAIT = S_L2_WAIT,
    ST_DONE    = S_DONE
  } ptw_state_t;

  // Each table entry is one 32-bit word, so the index is scaled by 4.
  function automatic logic [31:0] index_offset(input logic [9:0] idx);
    return {20'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/pte_decode.sv
// pte_decode: purely combinational classification of one page-table entry.
// Ports:
//   pte        in  32  raw PTE word
//   is_leaf    out 1   V and at least one of R/W/X
//   is_pointer out 1   V with R/W/X all clear
//   is_invalid out 1   V clear
//   next_base  out 32  next-level table base ({pte[31:4],4'b0})
//   ppn        out 20  pte[31:12]
//   flags      out 4   pte[3:0]
module pte_decode
  import ptw_pkg::*;
(
  input  logic [31:0] pte,
  output logic        is_leaf,
  output logic        is_pointer,
  output logic        is_invalid,
  output logic [31:0] next_base,
  output logic [19:0] ppn,
  output logic [3:0]  flags
);

  logic any_perm;

  assign any_perm   = pte[PTE_R] | pte[PTE_W] | pte[PTE_X];
  assign is_invalid = ~pte[PTE_V];
  assign is_leaf    = pte[PTE_V] & any_perm;
  assign is_pointer = pte[PTE_V] & ~any_perm;
  assign next_base  = pte & PTE_BASE_MASK;
  assign ppn        = pte[31:12];
  assign flags      = pte[3:0];

endmodule

// File: rtl/page_table_walker.sv
// page_table_walker: two-level walker between the TLB miss path and word memory.
// One walk in flight, no PTE caching. All outputs are registered.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid and ready are both high; the producer holds valid and payload stable
// until that edge, and never drops valid before it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   walk_req_valid_i    TLB walk request valid
//   walk_req_ready_o    walker idle, can accept
//   walk_vaddr_i        virtual address to translate
//   walk_resp_valid_o   walk result valid
//   walk_resp_ready_i   TLB accepts result
//   walk_ppn_o          leaf PPN
//   walk_flags_o        leaf flags
//   walk_fault_o        translation fault
//   mem_req_valid_o     memory read request valid
//   mem_req_ready_i     memory ready for request
//   mem_addr_o          PTE byte address
//   mem_resp_valid_i    memory data valid
//   mem_resp_ready_o    walker accepts memory data
//   mem_data_i          PTE read data
//   dbg_state           current FSM state (ptw_pkg S_* encoding)
module page_table_walker
  import ptw_pkg::*;
#(
  parameter logic [31:0] ROOT_BASE = ROOT_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        walk_req_valid_i,
  output logic        walk_req_ready_o,
  input  logic [31:0] walk_vaddr_i,
  output logic        walk_resp_valid_o,
  input  logic        walk_resp_ready_i,
  output logic [19:0] walk_ppn_o,
  output logic [3:0]  walk_flags_o,
  output logic        walk_fault_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_data_i,
  output logic [2:0]  dbg_state
);

  ptw_state_t  state;
  logic [9:0]  vpn0_q;   // only the L2 index is needed after the L1 address is formed

  logic        dec_is_leaf;
  logic        dec_is_pointer;
  logic        dec_is_invalid;
  logic [31:0] dec_next_base;
  logic [19:0] dec_ppn;
  logic [3:0]  dec_flags;
  logic        l1_fault;
  logic        l2_fault;

  // The page offset never takes part in the walk.
  logic        unused_offset;
  assign unused_offset = ^walk_vaddr_i[11:0];

  pte_decode u_pte_decode (
    .pte        (mem_data_i),
    .is_leaf    (dec_is_leaf),
    .is_pointer (dec_is_pointer),
    .is_invalid (dec_is_invalid),
    .next_base  (dec_next_base),
    .ppn        (dec_ppn),
    .flags      (dec_flags)
  );

  // Superpages are not supported, so a leaf at L1 is a fault just like V=0.
  assign l1_fault = dec_is_invalid | dec_is_leaf;
  assign l2_fault = dec_is_invalid | dec_is_pointer;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      vpn0_q            <= '0;
      walk_req_ready_o  <= 1'b1;
      walk_resp_valid_o <= 1'b0;
      walk_ppn_o        <= '0;
      walk_flags_o      <= '0;
      walk_fault_o      <= 1'b0;
      mem_req_valid_o   <= 1'b0;
      mem_addr_o        <= '0;
      mem_resp_ready_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (walk_req_valid_i && walk_req_ready_o) begin
            vpn0_q           <= walk_vaddr_i[21:12];
            walk_req_ready_o <= 1'b0;
            mem_addr_o       <= ROOT_BASE + index_offset(walk_vaddr_i[31:22]);
            mem_req_valid_o  <= 1'b1;
            state            <= ST_L1_REQ;
          end
        end

        ST_L1_REQ: begin
          if (mem_req_valid_o && mem_req_ready_i) begin
            mem_req_valid_o  <= 1'b0;
            mem_resp_ready_o <= 1'b1;
            state            <= ST_L1_WAIT;
          end
        end

        ST_L1_WAIT: begin
          if (mem_resp_valid_i && mem_resp_ready_o) begin
            mem_resp_ready_o <= 1'b0;
            if (l1_fault) begin
              walk_fault_o      <= 1'b1;
              walk_ppn_o        <= '0;
              walk_flags_o      <= '0;
              walk_resp_valid_o <= 1'b1;
              state             <= ST_DONE;
            end else begin
              mem_addr_o      <= dec_next_base + index_offset(vpn0_q);
              mem_req_valid_o <= 1'b1;
              state           <= ST_L2_REQ;
            end
          end
        end

        ST_L2_REQ: begin
          if (mem_req_valid_o && mem_req_ready_i) begin
            mem_req_valid_o  <= 1'b0;
            mem_resp_ready_o <= 1'b1;
            state            <= ST_L2_WAIT;
          end
        end

        ST_L2_WAIT: begin
          if (mem_resp_valid_i && mem_resp_ready_o) begin
            mem_resp_ready_o  <= 1'b0;
            walk_resp_valid_o <= 1'b1;
            if (l2_fault) begin
              walk_fault_o <= 1'b1;
              walk_ppn_o   <= '0;
              walk_flags_o <= '0;
            end else begin
              walk_fault_o <= 1'b0;
              walk_ppn_o   <= dec_ppn;
              walk_flags_o <= dec_flags;
            end
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Ready rises only after the accept edge, so no new request can be
          // taken on the same edge the result is consumed.
          if (walk_resp_ready_i) begin
            walk_resp_valid_o <= 1'b0;
            walk_req_ready_o  <= 1'b1;
            state             <= ST_IDLE;
          end
        end

        default: begin
          state            <= ST_IDLE;
          walk_req_ready_o <= 1'b1;
          mem_req_valid_o  <= 1'b0;
          mem_resp_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
